vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA sync generator: same counter structure, with every horizontal and vertical timing field as a parameter.
- Adds a pixel clock-enable, selectable sync polarity, registered glitch-free outputs, active-area pixel coordinates and line/frame start strobes.
- Sits between the board clock and the pixel/pattern generators; downstream blocks use px/py and vidon instead of decoding hc/vc themselves.

---
 rtl/vga_timing_gen.sv | 127 ++++++++++++
 tb/tb_vga_timing_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/timing generator with active-area coordinates and line/frame strobes; VGA_TIMING_FRAMECNT_EN adds frame_cnt.
// Outputs are registered from the next counter values, so they have zero latency to hc/vc; pix_en low holds all state and suppresses strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic          vidon,
    output logic [CW-1:0] px,
    output logic [CW-1:0] py,
    output logic          line_start,
`ifdef VGA_TIMING_FRAMECNT_EN
    output logic          frame_start,
    output logic [15:0]   frame_cnt
`else
    output logic          frame_start
`endif
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA0     = H_SYNC + H_BP;
    localparam int VA0     = V_SYNC + V_BP;

    localparam logic [CW-1:0] C_HMAX  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] C_VMAX  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_HA0   = CW'(HA0);
    localparam logic [CW-1:0] C_VA0   = CW'(VA0);
    // One extra bit so region ends equal to 2^CW do not truncate to zero
    localparam logic [CW:0]   C_HA1   = (CW+1)'(HA0 + H_ACTIVE);
    localparam logic [CW:0]   C_VA1   = (CW+1)'(VA0 + V_ACTIVE);
    localparam logic [CW:0]   C_HSYNC = (CW+1)'(H_SYNC);
    localparam logic [CW:0]   C_VSYNC = (CW+1)'(V_SYNC);
    localparam logic          L_HPOL  = (H_POL != 0);
    localparam logic          L_VPOL  = (V_POL != 0);

    if (H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_bad_cw
        $error("vga_timing_gen: CW=%0d cannot hold H_TOTAL=%0d or V_TOTAL=%0d", CW, H_TOTAL, V_TOTAL);
    end

    logic [CW-1:0] r_hc, r_vc, r_px, r_py;
    logic          r_hsync, r_vsync, r_vidon, r_line_start, r_frame_start;
    logic [CW-1:0] w_hc_nxt, w_vc_nxt;
    logic          w_h_wrap, w_v_wrap, w_h_act, w_v_act, w_wrap_en;

    assign w_h_wrap  = (r_hc == C_HMAX);
    assign w_v_wrap  = (r_vc == C_VMAX);
    assign w_wrap_en = pix_en && w_h_wrap;

    always_comb begin
        w_hc_nxt = r_hc;
        w_vc_nxt = r_vc;
        if (pix_en) begin
            w_hc_nxt = w_h_wrap ? '0 : r_hc + 1'b1;
            if (w_h_wrap) begin
                w_vc_nxt = w_v_wrap ? '0 : r_vc + 1'b1;
            end
        end
    end

    assign w_h_act = (w_hc_nxt >= C_HA0) && ({1'b0, w_hc_nxt} < C_HA1);
    assign w_v_act = (w_vc_nxt >= C_VA0) && ({1'b0, w_vc_nxt} < C_VA1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_px          <= '0;
            r_py          <= '0;
            r_hsync       <= L_HPOL;
            r_vsync       <= L_VPOL;
            r_vidon       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_hsync       <= ({1'b0, w_hc_nxt} < C_HSYNC) ? L_HPOL : ~L_HPOL;
            r_vsync       <= ({1'b0, w_vc_nxt} < C_VSYNC) ? L_VPOL : ~L_VPOL;
            r_vidon       <= w_h_act && w_v_act;
            r_px          <= (w_h_act && w_v_act) ? w_hc_nxt - C_HA0 : '0;
            r_py          <= (w_h_act && w_v_act) ? w_vc_nxt - C_VA0 : '0;
            r_line_start  <= w_wrap_en;
            r_frame_start <= w_wrap_en && w_v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_frame_cnt <= '0;
        end else if (w_wrap_en && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign hc          = r_hc;
    assign vc          = r_vc;
    assign px          = r_px;
    assign py          = r_py;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vidon       = r_vidon;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three instances (default 640x480, 800x600 positive sync, tiny 10x7 frame) checked against
// hand-computed checkpoints held in a cycle-ordered scoreboard queue, popped by a negedge monitor.
module tb_vga_timing_gen;

    localparam int U0 = 0, U1 = 16, U2 = 32;
    localparam int F_HC = 0, F_VC = 1, F_HS = 2, F_VS = 3, F_VID = 4, F_PX = 5, F_PY = 6, F_LS = 7, F_FS = 8, F_FC = 9;
    localparam int B  = 3;            // clr released after posedge 3: hc at cycle B+k equals k mod H_TOTAL
    localparam int B2 = B + 29202;    // release after the mid-line clr pulse on u0
    localparam int B3 = B2 + 802;     // release before the every-other-cycle pix_en run on u0

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic clr0, clr1, clr2, en0, en1, en2;

    logic        a_hs, a_vs, a_vid, a_ls, a_fs;
    logic [10:0] a_hc, a_vc, a_px, a_py;
    logic        b_hs, b_vs, b_vid, b_ls, b_fs;
    logic [10:0] b_hc, b_vc, b_px, b_py;
    logic        c_hs, c_vs, c_vid, c_ls, c_fs;
    logic [3:0]  c_hc, c_vc, c_px, c_py;
`ifdef VGA_TIMING_FRAMECNT_EN
    logic [15:0] a_fc, b_fc, c_fc;
`endif

    vga_timing_gen u0 (
        .clk(clk), .clr(clr0), .pix_en(en0), .hsync(a_hs), .vsync(a_vs), .hc(a_hc), .vc(a_vc),
        .vidon(a_vid), .px(a_px), .py(a_py), .line_start(a_ls),
`ifdef VGA_TIMING_FRAMECNT_EN
        .frame_cnt(a_fc),
`endif
        .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .H_POL(1), .V_POL(1), .CW(11)
    ) u1 (
        .clk(clk), .clr(clr1), .pix_en(en1), .hsync(b_hs), .vsync(b_vs), .hc(b_hc), .vc(b_vc),
        .vidon(b_vid), .px(b_px), .py(b_py), .line_start(b_ls),
`ifdef VGA_TIMING_FRAMECNT_EN
        .frame_cnt(b_fc),
`endif
        .frame_start(b_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(0), .V_POL(0), .CW(4)
    ) u2 (
        .clk(clk), .clr(clr2), .pix_en(en2), .hsync(c_hs), .vsync(c_vs), .hc(c_hc), .vc(c_vc),
        .vidon(c_vid), .px(c_px), .py(c_py), .line_start(c_ls),
`ifdef VGA_TIMING_FRAMECNT_EN
        .frame_cnt(c_fc),
`endif
        .frame_start(c_fs)
    );

    typedef struct {
        int at;
        int sel;
        int exp;
    } chk_t;

    chk_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    function automatic void ex(input int at, input int sel, input int exp);
        chk_t c;
        int   i;
        c.at  = at;
        c.sel = sel;
        c.exp = exp;
        i = q.size();
        while (i > 0 && q[i-1].at > at) i--;
        q.insert(i, c);
    endfunction

    function automatic int get_sig(input int sel);
        case (sel)
            U0+F_HC: return int'(a_hc);   U0+F_VC: return int'(a_vc);
            U0+F_HS: return int'(a_hs);   U0+F_VS: return int'(a_vs);
            U0+F_VID: return int'(a_vid); U0+F_PX: return int'(a_px);
            U0+F_PY: return int'(a_py);   U0+F_LS: return int'(a_ls);
            U0+F_FS: return int'(a_fs);
            U1+F_HC: return int'(b_hc);   U1+F_VC: return int'(b_vc);
            U1+F_HS: return int'(b_hs);   U1+F_VS: return int'(b_vs);
            U1+F_VID: return int'(b_vid); U1+F_PX: return int'(b_px);
            U1+F_PY: return int'(b_py);   U1+F_LS: return int'(b_ls);
            U1+F_FS: return int'(b_fs);
            U2+F_HC: return int'(c_hc);   U2+F_VC: return int'(c_vc);
            U2+F_HS: return int'(c_hs);   U2+F_VS: return int'(c_vs);
            U2+F_VID: return int'(c_vid); U2+F_PX: return int'(c_px);
            U2+F_PY: return int'(c_py);   U2+F_LS: return int'(c_ls);
            U2+F_FS: return int'(c_fs);
`ifdef VGA_TIMING_FRAMECNT_EN
            U0+F_FC: return int'(a_fc);
            U2+F_FC: return int'(c_fc);
`endif
            default: return -1;
        endcase
    endfunction

    function automatic string sig_name(input int sel);
        string u, f;
        case (sel / 16)
            0: u = "u0";
            1: u = "u1";
            default: u = "u2";
        endcase
        case (sel % 16)
            F_HC: f = "hc";   F_VC: f = "vc";   F_HS: f = "hsync"; F_VS: f = "vsync";
            F_VID: f = "vidon"; F_PX: f = "px"; F_PY: f = "py";   F_LS: f = "line_start";
            F_FS: f = "frame_start";
            default: f = "frame_cnt";
        endcase
        return {u, ".", f};
    endfunction

    always @(negedge clk) begin
        int act;
        while (q.size() > 0 && q[0].at <= cyc) begin
            total++;
            if (q[0].at < cyc) begin
                bad++;
                $display("FAIL %s: checkpoint at cycle %0d skipped (now %0d), expected %0d", sig_name(q[0].sel), q[0].at, cyc, q[0].exp);
            end else begin
                act = get_sig(q[0].sel);
                if (act != q[0].exp) begin
                    bad++;
                    $display("FAIL %s @cycle %0d: got %0d, expected %0d", sig_name(q[0].sel), cyc, act, q[0].exp);
                end
            end
            void'(q.pop_front());
        end
        if (done) begin
            while (q.size() > 0) begin
                total++;
                bad++;
                $display("FAIL %s: checkpoint at cycle %0d never reached, expected %0d", sig_name(q[0].sel), q[0].at, q[0].exp);
                void'(q.pop_front());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    initial begin
        clr0 = 1'b1; clr1 = 1'b1; clr2 = 1'b1;
        en0  = 1'b0; en1  = 1'b0; en2  = 1'b0;

        // Reset state for all three instances
        for (int f = F_HC; f <= F_FS; f++) begin
            if (f != F_HS && f != F_VS) begin
                ex(2, U0 + f, 0);
                ex(2, U2 + f, 0);
            end
        end
        ex(2, U0+F_HS, 0); ex(2, U0+F_VS, 0);
        ex(2, U1+F_HS, 1); ex(2, U1+F_VS, 1); ex(2, U1+F_HC, 0); ex(2, U1+F_VID, 0);

        // u0: default 640x480 timing
        ex(B+1, U0+F_HC, 1);
        ex(B+95, U0+F_HS, 0);  ex(B+96, U0+F_HS, 1);  ex(B+96, U0+F_HC, 96);
        ex(B+799, U0+F_HC, 799); ex(B+799, U0+F_LS, 0);
        ex(B+800, U0+F_HC, 0); ex(B+800, U0+F_VC, 1); ex(B+800, U0+F_LS, 1); ex(B+800, U0+F_FS, 0);
        ex(B+801, U0+F_LS, 0); ex(B+801, U0+F_HC, 1);
        ex(B+1599, U0+F_VS, 0); ex(B+1599, U0+F_VC, 1);
        ex(B+1600, U0+F_VS, 1); ex(B+1600, U0+F_VC, 2);
        ex(B+28143, U0+F_VID, 0);
        ex(B+28144, U0+F_VID, 1); ex(B+28144, U0+F_HC, 144); ex(B+28144, U0+F_VC, 35);
        ex(B+28144, U0+F_PX, 0);  ex(B+28144, U0+F_PY, 0);
        ex(B+28783, U0+F_VID, 1); ex(B+28783, U0+F_PX, 639); ex(B+28783, U0+F_HC, 783);
        ex(B+28784, U0+F_VID, 0); ex(B+28784, U0+F_PX, 0);
        ex(B+29200, U0+F_HC, 400); ex(B+29200, U0+F_VC, 36); ex(B+29200, U0+F_PX, 256);
        ex(B+29200, U0+F_PY, 1);   ex(B+29200, U0+F_VID, 1);
        // clr asserted between edges: outputs must already be at reset values
        ex(B+29201, U0+F_HC, 0); ex(B+29201, U0+F_VC, 0); ex(B+29201, U0+F_VID, 0);
        ex(B+29201, U0+F_PX, 0); ex(B+29201, U0+F_PY, 0); ex(B+29201, U0+F_HS, 0); ex(B+29201, U0+F_VS, 0);
        ex(B2+799, U0+F_HC, 799); ex(B2+799, U0+F_LS, 0);
        ex(B2+800, U0+F_LS, 1);   ex(B2+800, U0+F_HC, 0); ex(B2+800, U0+F_VC, 1);
        // pix_en every other clock: 1600-clock lines, 192-clock hsync
        ex(B3+190, U0+F_HS, 0);  ex(B3+191, U0+F_HS, 1); ex(B3+191, U0+F_HC, 96);
        ex(B3+1598, U0+F_HC, 799); ex(B3+1598, U0+F_LS, 0);
        ex(B3+1599, U0+F_LS, 1); ex(B3+1599, U0+F_HC, 0); ex(B3+1599, U0+F_VC, 1);
        ex(B3+1600, U0+F_LS, 0); ex(B3+1600, U0+F_HC, 0);
        ex(B3+1790, U0+F_HS, 0); ex(B3+1791, U0+F_HS, 1);
        ex(B3+3199, U0+F_LS, 1); ex(B3+3199, U0+F_VC, 2); ex(B3+3200, U0+F_LS, 0);

        // u1: 800x600, positive sync, H_TOTAL=1056, V_TOTAL=628
        ex(B+127, U1+F_HS, 1); ex(B+128, U1+F_HS, 0); ex(B+128, U1+F_HC, 128);
        ex(B+1055, U1+F_HC, 1055); ex(B+1055, U1+F_LS, 0);
        ex(B+1056, U1+F_HC, 0); ex(B+1056, U1+F_VC, 1); ex(B+1056, U1+F_LS, 1);
        ex(B+4223, U1+F_VS, 1); ex(B+4223, U1+F_VC, 3);
        ex(B+4224, U1+F_VS, 0); ex(B+4224, U1+F_VC, 4);
        ex(B+28727, U1+F_VID, 0);
        ex(B+28728, U1+F_VID, 1); ex(B+28728, U1+F_HC, 216); ex(B+28728, U1+F_VC, 27);
        ex(B+28728, U1+F_PX, 0);  ex(B+28728, U1+F_PY, 0);

        // u2: 10x7 frame, active hc 4..7, vc 3..5, CW=4
        ex(B+10, U2+F_HC, 0); ex(B+10, U2+F_VC, 1); ex(B+10, U2+F_LS, 1); ex(B+10, U2+F_FS, 0);
        ex(B+19, U2+F_VS, 0); ex(B+20, U2+F_VS, 1); ex(B+20, U2+F_VC, 2);
        ex(B+33, U2+F_VID, 0);
        ex(B+34, U2+F_VID, 1); ex(B+34, U2+F_HC, 4); ex(B+34, U2+F_VC, 3); ex(B+34, U2+F_PX, 0); ex(B+34, U2+F_PY, 0);
        ex(B+35, U2+F_PX, 1);
        ex(B+38, U2+F_VID, 0); ex(B+38, U2+F_PX, 0);
        ex(B+57, U2+F_VID, 1); ex(B+57, U2+F_PX, 3); ex(B+57, U2+F_PY, 2);
        ex(B+58, U2+F_VID, 0); ex(B+58, U2+F_PX, 0); ex(B+58, U2+F_PY, 0);
        ex(B+69, U2+F_HC, 9); ex(B+69, U2+F_VC, 6); ex(B+69, U2+F_FS, 0); ex(B+69, U2+F_LS, 0);
        ex(B+70, U2+F_HC, 0); ex(B+70, U2+F_VC, 0); ex(B+70, U2+F_LS, 1); ex(B+70, U2+F_FS, 1);
        ex(B+71, U2+F_FS, 0); ex(B+71, U2+F_LS, 0); ex(B+71, U2+F_HC, 1);
        ex(B+140, U2+F_FS, 1);
        // pix_en low for three clocks right after a frame_start: strobes drop, counters hold
        ex(B+141, U2+F_FS, 0); ex(B+141, U2+F_LS, 0); ex(B+141, U2+F_HC, 0);
        ex(B+143, U2+F_FS, 0); ex(B+143, U2+F_HC, 0); ex(B+143, U2+F_VC, 0);
        ex(B+144, U2+F_HC, 1);
        ex(B+212, U2+F_HC, 9); ex(B+212, U2+F_FS, 0);
        ex(B+213, U2+F_FS, 1); ex(B+213, U2+F_HC, 0); ex(B+213, U2+F_VC, 0);
`ifdef VGA_TIMING_FRAMECNT_EN
        ex(2, U0+F_FC, 0); ex(2, U2+F_FC, 0); ex(B+800, U0+F_FC, 0);
        ex(B+69, U2+F_FC, 0);  ex(B+70, U2+F_FC, 1);  ex(B+140, U2+F_FC, 2);
        ex(B+212, U2+F_FC, 2); ex(B+213, U2+F_FC, 3);
        ex(B+230, U2+F_FC, 65535); ex(B+282, U2+F_FC, 65535);
        ex(B+283, U2+F_FC, 0);     ex(B+283, U2+F_FS, 1);
`endif

        at_cyc(B);
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
        en0  = 1'b1; en1  = 1'b1; en2  = 1'b1;

        fork
            begin
                at_cyc(B+29201); clr0 = 1'b1;
                at_cyc(B2);      clr0 = 1'b0;
                at_cyc(B2+801);  clr0 = 1'b1;
                at_cyc(B3);      clr0 = 1'b0;
                for (int j = 1; j <= 3200; j++) begin
                    at_cyc(B3 + j);
                    en0 = (j % 2 == 0);
                end
                en0 = 1'b1;
            end
            begin
                at_cyc(B+140); en2 = 1'b0;
                at_cyc(B+143); en2 = 1'b1;
`ifdef VGA_TIMING_FRAMECNT_EN
                at_cyc(B+220); force u2.r_frame_cnt = 16'hFFFF;
                at_cyc(B+221); release u2.r_frame_cnt;
`endif
            end
        join

        repeat (3) @(posedge clk);
        done = 1'b1;
    end

endmodule
